// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Routes a single valid/ready input stream to one of NUM_OUTPUTS output
//   channels. Each beat carries its own destination index. Beats are buffered
//   in a 2-entry in-order FIFO, so a blocked channel stalls the whole stream
//   rather than letting later beats overtake it. Beats addressed to a channel
//   that does not exist are consumed and counted instead of being stored.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   in_valid       : upstream beat present
//   in_ready       : block accepts a beat this cycle (FIFO not full)
//   in_data        : beat payload, DATA_WIDTH bits
//   in_select      : destination channel index
//   out_valid      : one-hot valid, bit i belongs to channel i
//   out_ready      : per-channel ready, only the addressed bit is used
//   out_data_flat  : lane i is [i*DATA_WIDTH +: DATA_WIDTH], unused lanes zero
//   drop_pulse     : one-cycle flag after a beat with an illegal index
//   drop_count     : saturating count of dropped beats
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int NUM_OUTPUTS = 4,
  localparam int SEL_W       = $clog2(NUM_OUTPUTS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [SEL_W-1:0]                  in_select,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  input  logic [NUM_OUTPUTS-1:0]            out_ready,
  output logic [DATA_WIDTH*NUM_OUTPUTS-1:0] out_data_flat,
  output logic                              drop_pulse,
  output logic [7:0]                        drop_count
);

  localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUTPUTS);

  // FIFO storage; the contents need no reset because occupancy gates them.
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [SEL_W-1:0]      sel_q  [2];

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  logic       drop_pulse_q, drop_pulse_d;
  logic [7:0] drop_count_q, drop_count_d;

  logic                  accept;
  logic                  drop;
  logic                  push;
  logic                  pop;
  logic                  not_empty;
  logic [SEL_W-1:0]      head_sel;
  logic [DATA_WIDTH-1:0] head_data;

  // Gating with rst_n keeps in_ready low during reset and lets it rise as
  // soon as reset is released, without waiting for a clock edge.
  assign in_ready  = rst_n && (count_q < 2'd2);
  assign accept    = in_valid && in_ready;
  assign drop      = ({1'b0, in_select} >= NUM_OUT_L);
  assign push      = accept && !drop;
  assign not_empty = (count_q != 2'd0);
  assign head_sel  = sel_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  // Only the addressed channel has its valid raised, so masking with
  // out_valid ignores the ready of every other channel.
  assign pop = |(out_valid & out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_lane
      assign out_valid[gi] = not_empty && (head_sel == SEL_W'(gi));
      assign out_data_flat[gi*DATA_WIDTH +: DATA_WIDTH] =
        out_valid[gi] ? head_data : '0;
    end
  endgenerate

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_pulse_d = 1'b0;
    drop_count_d = drop_count_q;

    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // A full FIFO never pushes, so this stays within 0..2.
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (accept && drop) begin
      drop_pulse_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= in_data;
      sel_q[wr_ptr_q]  <= in_select;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Drives two instances: index 0 uses the defaults (4 channels), index 1 uses
//   3 channels so that select value 3 is an illegal destination. A queue-style
//   reference model (head always at slot 0) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv   [2];
  logic [7:0] idat [2];
  logic [1:0] isel [2];
  logic [3:0] ordy [2];

  logic        ir4, ir3, dp4, dp3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [7:0]  dc4, dc3;

  stream_demux dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir4), .in_data(idat[0]), .in_select(isel[0]),
    .out_valid(ov4), .out_ready(ordy[0]), .out_data_flat(od4),
    .drop_pulse(dp4), .drop_count(dc4)
  );

  stream_demux #(.DATA_WIDTH(8), .NUM_OUTPUTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir3), .in_data(idat[1]), .in_select(isel[1]),
    .out_valid(ov3), .out_ready(ordy[1][2:0]), .out_data_flat(od3),
    .drop_pulse(dp3), .drop_count(dc3)
  );

  logic [3:0]  ov [2];
  logic [31:0] od [2];
  logic        ir [2];
  logic        dp [2];
  logic [7:0]  dc [2];
  always_comb begin
    ov[0] = ov4;            ov[1] = {1'b0, ov3};
    od[0] = od4;            od[1] = {8'h00, od3};
    ir[0] = ir4;            ir[1] = ir3;
    dp[0] = dp4;            dp[1] = dp3;
    dc[0] = dc4;            dc[1] = dc3;
  end

  // Reference model: cnt beats waiting, head at slot 0.
  int         cnt      [2];
  logic [7:0] m_data   [2][2];
  logic [1:0] m_sel    [2][2];
  logic       m_dp     [2];
  int         m_dc     [2];
  int         delivered[2];
  int         nch      [2];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      cnt[k]  = 0;
      m_dp[k] = 1'b0;
      m_dc[k] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] e_ov, e_od;
      e_ov = (cnt[k] > 0) ? (32'd1 << m_sel[k][0]) : 32'd0;
      e_od = (cnt[k] > 0) ? (32'(m_data[k][0]) << (8 * m_sel[k][0])) : 32'd0;
      check($sformatf("%s_ov%0d", tag, k), 32'(ov[k]), e_ov);
      check($sformatf("%s_od%0d", tag, k), od[k], e_od);
      check($sformatf("%s_ir%0d", tag, k), 32'(ir[k]), 32'(rst_n && (cnt[k] < 2)));
      check($sformatf("%s_dp%0d", tag, k), 32'(dp[k]), 32'(m_dp[k]));
      check($sformatf("%s_dc%0d", tag, k), 32'(dc[k]), 32'(m_dc[k]));
    end
  endtask

  // One clock: inputs were set after the previous edge; model the edge, then
  // compare every output 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit acc, pop, bad;
      acc = iv[k] && (cnt[k] < 2);
      bad = acc && (int'(isel[k]) >= nch[k]);
      pop = (cnt[k] > 0) && ordy[k][m_sel[k][0]];
      if (pop) begin
        $display("[TB] inst%0d deliver ch=%0d data=0x%02h", k, m_sel[k][0], m_data[k][0]);
        delivered[k]++;
        m_data[k][0] = m_data[k][1];
        m_sel[k][0]  = m_sel[k][1];
        cnt[k]--;
      end
      if (acc && !bad) begin
        m_data[k][cnt[k]] = idat[k];
        m_sel[k][cnt[k]]  = isel[k];
        cnt[k]++;
      end
      m_dp[k] = bad;
      if (bad && m_dc[k] < 255) m_dc[k]++;
    end
    #1;
    check_all(tag);
  endtask

  // Reset asserted and released between clock edges (called at edge+1).
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all("rst");
    #2 rst_n = 1'b1;
    #1 check_all("rel");
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; idat[k] = 8'h00; isel[k] = 2'd0; ordy[k] = 4'hF;
    end
  endtask

  initial begin
    nch[0] = 4; nch[1] = 3;
    delivered[0] = 0; delivered[1] = 0;
    idle_inputs();
    model_clear();
    rst_n = 1'b0;
    #1 check_all("init");
    #1 rst_n = 1'b1;
    #1 check_all("init_rel");
    step("idle");

    // Single beat to channel 2.
    iv[0] = 1'b1; idat[0] = 8'hA5; isel[0] = 2'd2;
    step("single");
    iv[0] = 1'b0;
    check("single_ov", 32'(ov[0]), 32'h4);
    check("single_od", od[0], 32'h00A5_0000);
    step("single2");
    check("single_empty", 32'(ov[0]), 32'h0);

    // Backpressure: two beats queued behind a blocked channel 1.
    ordy[0] = 4'h0;
    iv[0] = 1'b1; idat[0] = 8'h11; isel[0] = 2'd1;
    step("bp1");
    idat[0] = 8'h22; isel[0] = 2'd3;
    step("bp2");
    iv[0] = 1'b0;
    check("bp_full_ir", 32'(ir[0]), 32'h0);
    check("bp_ov", 32'(ov[0]), 32'h2);
    iv[0] = 1'b1; idat[0] = 8'h99; isel[0] = 2'd0;  // ignored while full
    step("bp_hold1");
    iv[0] = 1'b0;
    step("bp_hold2");
    check("bp_hold_od", od[0], 32'h0000_1100);
    ordy[0] = 4'b0010;
    step("bp_pop1");
    check("bp_ov2", 32'(ov[0]), 32'h8);
    check("bp_od2", od[0], 32'h2200_0000);
    ordy[0] = 4'hF;
    step("bp_pop2");
    check("bp_done", 32'(ov[0]), 32'h0);

    // Streaming 16 beats back to back.
    delivered[0] = 0;
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1'b1; idat[0] = 8'(i); isel[0] = 2'(i % 4);
      step("stream");
      check("stream_ir", 32'(ir[0]), 32'h1);
    end
    iv[0] = 1'b0;
    check("stream_last", od[0], 32'h0F00_0000);
    step("stream_end");
    check("stream_count", 32'(delivered[0]), 32'd16);

    // Drops on the 3-channel instance.
    do_reset();
    iv[1] = 1'b1; idat[1] = 8'h5A; isel[1] = 2'd3;
    step("drop1");
    iv[1] = 1'b0;
    check("drop_pulse", 32'(dp[1]), 32'h1);
    check("drop_cnt1", 32'(dc[1]), 32'h1);
    check("drop_ov", 32'(ov[1]), 32'h0);
    step("drop1b");
    check("drop_pulse_off", 32'(dp[1]), 32'h0);
    iv[1] = 1'b1;
    for (int i = 0; i < 299; i++) step("drop_n");
    iv[1] = 1'b0;
    check("drop_sat", 32'(dc[1]), 32'd255);

    // Randomized mixed traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        idat[k] = 8'($urandom);
        isel[k] = 2'($urandom_range(0, 3));
        ordy[k] = 4'($urandom);
      end
      step("rand");
    end

    // Reset with a full FIFO between edges; nothing stale may appear after.
    idle_inputs();
    ordy[0] = 4'h0;
    iv[0] = 1'b1; idat[0] = 8'h33; isel[0] = 2'd0;
    step("fill1");
    idat[0] = 8'h44; isel[0] = 2'd1;
    step("fill2");
    iv[0] = 1'b0;
    check("fill_ir", 32'(ir[0]), 32'h0);
    do_reset();
    ordy[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step("post_rst");
      check("post_rst_ov", 32'(ov[0]), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, as the bit width of each data lane.
REQ-002 The block SHALL take parameter NUM_OUTPUTS, default 4, as the number of output channels; legal range is 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream beat is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits: the beat payload.
REQ-008 The block SHALL have port in_select, input, $clog2(NUM_OUTPUTS) bits: the destination channel index.
REQ-009 The block SHALL have port out_valid, output, NUM_OUTPUTS bits: bit i is the valid for channel i.
REQ-010 The block SHALL have port out_ready, input, NUM_OUTPUTS bits: bit i is the ready from channel i.
REQ-011 The block SHALL have port out_data_flat, output, DATA_WIDTH*NUM_OUTPUTS bits: lane i is [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 The block SHALL have port drop_pulse, output, 1 bit: a one-cycle flag marking a dropped beat.
REQ-013 The block SHALL have port drop_count, output, 8 bits: the saturating count of dropped beats.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 The block SHALL store accepted beats, as {in_data, in_select}, in a 2-entry in-order FIFO.
REQ-016 in_ready SHALL equal (occupancy < 2), derived from registered state only, with no combinational path from out_ready or in_valid.
REQ-017 When the FIFO is non-empty with head select s, out_valid SHALL be one-hot at bit s, and all other bits SHALL be 0.
REQ-018 Lane s of out_data_flat SHALL carry the head data; all other lanes SHALL be driven to zero.
REQ-019 When the FIFO is empty, out_valid SHALL be 0 and out_data_flat SHALL be all zeros.
REQ-020 The head SHALL be popped on a rising edge where out_valid[s]=1 and out_ready[s]=1.
REQ-021 out_ready bits of non-selected channels SHALL be ignored.
REQ-022 Latency SHALL be 1 cycle: a beat accepted at edge N into an empty FIFO appears on out_valid in the cycle after edge N.
REQ-023 Sustained throughput SHALL be 1 beat/cycle when the destination holds out_ready=1.
REQ-024 A push and a pop on the same edge SHALL leave occupancy unchanged and preserve order.
REQ-025 When full, in_ready SHALL be 0 for that cycle, even if a pop occurs on the same edge; there is no pass-through.
REQ-026 A head blocked by out_ready[s]=0 SHALL hold its data and select stable until popped, with no head-of-line reordering.
REQ-027 When accepted, a beat with in_select >= NUM_OUTPUTS SHALL be discarded, not stored.
REQ-028 On such a discard, drop_pulse SHALL be asserted for exactly the cycle after the accepting edge.
REQ-029 On such a discard, drop_count SHALL increment by 1, saturating at 255.
REQ-030 Beats with in_select >= NUM_OUTPUTS SHALL occupy no FIFO slot.
REQ-031 FIFO read/write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-032 Occupancy SHALL be 2 bits wide, range 0..2, and never exceed 2.
REQ-033 in_data and in_select SHALL be sampled only on accepting edges; values while in_ready=0 have no effect.

Reset
REQ-034 rst_n=0 SHALL immediately, with no clock required, clear occupancy and pointers to 0.
REQ-035 While rst_n=0, out_valid SHALL be 0, out_data_flat 0, in_ready 0, drop_pulse 0, and drop_count 0.
REQ-036 in_ready SHALL rise to 1 in the first cycle after rst_n deasserts, with no clock edge needed beyond the deassertion.
REQ-037 Reset mid-transfer SHALL discard all buffered beats, which are not delivered after reset.

Verification
REQ-038 Defaults, single beat: in_data=0xA5, in_select=2, out_ready=4'b1111 -> next cycle out_valid=4'b0100 and lane 2=0xA5, other lanes 0; one cycle later out_valid=0.
REQ-039 Backpressure: out_ready=0, push 0x11 to channel 1 and 0x22 to channel 3 -> in_ready=0 after the second accept, out_valid=4'b0010 held; raising out_ready[1] delivers 0x11, then out_valid=4'b1000 with 0x22.
REQ-040 Streaming: 16 back-to-back beats, data 0..15, select=i mod 4, all out_ready=1 -> in_ready stays 1 throughout, all beats are delivered in order one per cycle, and the last beat appears 1 cycle after the last accept.
REQ-041 Drop: NUM_OUTPUTS=3, push with in_select=3 -> drop_pulse=1 for one cycle, drop_count=1, out_valid stays 0; after 300 such pushes drop_count=255.
REQ-042 Async reset: FIFO full, assert rst_n=0 between clock edges -> out_valid=0, in_ready=0, drop_count=0 immediately; after release, no stale beat is delivered.
